// File: rtl/im_sram_loader_pkg.sv
// Shared definitions for the item-memory SRAM loader.
//   - FSM state encoding (IDLE / LOAD / WRITE / DONE)
//   - calc_beats(): input beats needed to fill one SRAM word
//   - cnt_width(): beat counter width (never below 1 bit)
// `HV_DIMENSION and `ceilLog2 normally come from the project const.vh.
// Fallback definitions below keep this slice self-contained when that
// header has not been read first.
`ifndef HV_DIMENSION
`define HV_DIMENSION 256
`endif
`ifndef ceilLog2
`define ceilLog2(x) ($clog2(x))
`endif

package im_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // ceil(fold_w / in_w): a partially used last beat still costs a full beat
  function automatic int calc_beats(input int fold_w, input int in_w);
    return (fold_w + in_w - 1) / in_w;
  endfunction

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? `ceilLog2(beats) : 1;
  endfunction

endpackage

// File: rtl/im_sram_loader_if.sv
// Stream-in / SRAM-write bus of the item-memory loader.
//   din_valid, din, din_ready : input beat handshake
//   we, im_write_addr, im_din : SRAM write port toward the fusion top
// master: the loader side (consumes beats, drives the SRAM port)
// slave : the environment side (produces beats, observes the SRAM port)
interface im_sram_loader_if #(
  parameter int IN_WIDTH        = 32,
  parameter int FOLD_WIDTH      = `HV_DIMENSION / 4,
  parameter int SRAM_ADDR_WIDTH = 10
);
  logic                       din_valid;
  logic                       din_ready;
  logic [IN_WIDTH-1:0]        din;
  logic                       we;
  logic [SRAM_ADDR_WIDTH-1:0] im_write_addr;
  logic [FOLD_WIDTH-1:0]      im_din;

  modport master (
    input  din_valid, din,
    output din_ready, we, im_write_addr, im_din
  );

  modport slave (
    output din_valid, din,
    input  din_ready, we, im_write_addr, im_din
  );
endinterface

// File: rtl/im_sram_loader_packer.sv
// im_word_packer: collects IN_WIDTH beats little-endian into one
// FOLD_WIDTH word.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart collection at beat 0
//   beat_vld   : a beat is accepted this cycle
//   beat       : beat data
//   word_full  : the accepted beat completes a word (combinational)
//   word       : packed word including the beat accepted this cycle
module im_word_packer
  import im_loader_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int FOLD_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  beat_vld,
  input  logic [IN_WIDTH-1:0]   beat,
  output logic                  word_full,
  output logic [FOLD_WIDTH-1:0] word
);
  localparam int BEATS  = calc_beats(FOLD_WIDTH, IN_WIDTH);
  localparam int CNT_W  = cnt_width(BEATS);
  localparam int PACK_W = BEATS * IN_WIDTH;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PACK_W-1:0] pack_q, pack_d;

  always_comb begin
    cnt_d     = cnt_q;
    pack_d    = pack_q;
    word_full = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (beat_vld) begin
      pack_d[cnt_q*IN_WIDTH +: IN_WIDTH] = beat;
      if (cnt_q == CNT_W'(BEATS - 1)) begin
        word_full = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Bits of the last beat above FOLD_WIDTH are dropped here.
  assign word = pack_d[FOLD_WIDTH-1:0];

  // Every pack bit is rewritten before word_full, so only the counter resets.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
    pack_q <= pack_d;
  end
endmodule

// File: rtl/im_sram_loader.sv
// im_sram_loader: streams item-memory contents into the IM SRAM, one
// FOLD_WIDTH word per BEATS input beats, NUM_WORDS words per load.
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse, begins a full load from IDLE or DONE
//   bus       : im_sram_loader_if.master (beat handshake + SRAM write port)
//   busy      : high while loading or writing
//   load_done : all NUM_WORDS written; held until start or rst
//   checksum  : XOR of beats since last start (only with IM_LOADER_CHECKSUM_EN)
// NUM_WORDS must not exceed 2**SRAM_ADDR_WIDTH.
module im_sram_loader
  import im_loader_pkg::*;
#(
  parameter int NUM_FOLDS       = 4,
  parameter int FOLD_WIDTH      = `HV_DIMENSION / NUM_FOLDS,
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int IN_WIDTH        = 32,
  parameter int NUM_WORDS       = 856
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  im_sram_loader_if.master bus,
  output logic             busy,
  output logic             load_done
`ifdef IM_LOADER_CHECKSUM_EN
  ,
  output logic [IN_WIDTH-1:0] checksum
`endif
);
  state_t                     state_q, state_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;   // next word to be written
  logic [SRAM_ADDR_WIDTH-1:0] wa_q, wa_d;       // address presented to SRAM
  logic [FOLD_WIDTH-1:0]      im_din_q, im_din_d;

  logic                  accept, start_ok, pk_clr, pk_full;
  logic [FOLD_WIDTH-1:0] pk_word;

  assign accept   = (state_q == ST_LOAD) && bus.din_valid;
  // start is honoured only when no load is in flight
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  im_word_packer #(
    .IN_WIDTH   (IN_WIDTH),
    .FOLD_WIDTH (FOLD_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr),
    .beat_vld  (accept),
    .beat      (bus.din),
    .word_full (pk_full),
    .word      (pk_word)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wa_d     = wa_q;
    im_din_d = im_din_q;
    pk_clr   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          pk_clr  = 1'b1;
        end
      end
      ST_LOAD: begin
        // Latch the completed word so the SRAM port holds it after WRITE.
        if (pk_full) begin
          state_d  = ST_WRITE;
          wa_d     = addr_q;
          im_din_d = pk_word;
        end
      end
      ST_WRITE: begin
        if (addr_q == SRAM_ADDR_WIDTH'(NUM_WORDS - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
          addr_d  = addr_q + SRAM_ADDR_WIDTH'(1);
          pk_clr  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wa_q     <= '0;
      im_din_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wa_q     <= wa_d;
      im_din_q <= im_din_d;
    end
  end

  assign bus.din_ready     = (state_q == ST_LOAD);
  assign bus.we            = (state_q == ST_WRITE);
  assign bus.im_write_addr = wa_q;
  assign bus.im_din        = im_din_q;
  assign busy              = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign load_done         = (state_q == ST_DONE);

`ifdef IM_LOADER_CHECKSUM_EN
  logic [IN_WIDTH-1:0] cs_q, cs_d;

  always_comb begin
    cs_d = cs_q;
    if (start_ok)    cs_d = '0;
    else if (accept) cs_d = cs_q ^ bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) cs_q <= '0;
    else     cs_q <= cs_d;
  end

  assign checksum = cs_q;
`endif
endmodule

// File: tb/tb_im_sram_loader.sv
// Bench for im_sram_loader: two instances (FOLD_WIDTH 64 and 40, both
// IN_WIDTH 32, NUM_WORDS 3) share one stimulus stream and are checked
// against a transaction-level reference model every cycle.
module tb_im_sram_loader;
  localparam int NW    = 3;
  localparam int BEATS = 2;

  logic clk;
  logic drv_rst, drv_start, drv_valid;
  logic [31:0] drv_din;
  logic busy_a, done_a, busy_b, done_b;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] cs_a, cs_b;
`endif

  im_sram_loader_if #(.IN_WIDTH(32), .FOLD_WIDTH(64), .SRAM_ADDR_WIDTH(10)) bus_a ();
  im_sram_loader_if #(.IN_WIDTH(32), .FOLD_WIDTH(40), .SRAM_ADDR_WIDTH(10)) bus_b ();

  assign bus_a.din_valid = drv_valid;
  assign bus_a.din       = drv_din;
  assign bus_b.din_valid = drv_valid;
  assign bus_b.din       = drv_din;

  im_sram_loader #(.NUM_FOLDS(4), .FOLD_WIDTH(64), .SRAM_ADDR_WIDTH(10),
                   .IN_WIDTH(32), .NUM_WORDS(NW)) u_a (
    .clk(clk), .rst(drv_rst), .start(drv_start), .bus(bus_a),
    .busy(busy_a), .load_done(done_a)
`ifdef IM_LOADER_CHECKSUM_EN
    , .checksum(cs_a)
`endif
  );

  im_sram_loader #(.NUM_FOLDS(4), .FOLD_WIDTH(40), .SRAM_ADDR_WIDTH(10),
                   .IN_WIDTH(32), .NUM_WORDS(NW)) u_b (
    .clk(clk), .rst(drv_rst), .start(drv_start), .bus(bus_b),
    .busy(busy_b), .load_done(done_b)
`ifdef IM_LOADER_CHECKSUM_EN
    , .checksum(cs_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a load in progress collects beats; every BEATS beats
  // produce one write in the following cycle; after NW writes it is done.
  bit          m_active, m_wr, m_done;
  int          m_word, m_nb;
  logic [63:0] m_acc, m_wdata;
  logic [9:0]  m_waddr;
  logic [31:0] m_cs;

  logic [9:0] wr_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit v, input logic [31:0] d);
    if (r) begin
      m_active = 0; m_wr = 0; m_done = 0; m_word = 0; m_nb = 0;
      m_acc = '0; m_wdata = '0; m_waddr = '0; m_cs = '0;
    end else if (m_wr) begin
      m_wr = 0;
      m_word++;
      if (m_word == NW) begin
        m_active = 0;
        m_done   = 1;
      end else begin
        m_nb = 0;
      end
    end else if (m_active) begin
      if (v) begin
        m_acc[m_nb*32 +: 32] = d;
        m_cs = m_cs ^ d;
        m_nb++;
        if (m_nb == BEATS) begin
          m_wr    = 1;
          m_wdata = m_acc;
          m_waddr = 10'(m_word);
        end
      end
    end else if (s) begin
      m_active = 1; m_done = 0; m_word = 0; m_nb = 0; m_cs = '0;
    end
  endtask

  task automatic check_model();
    chk("we_a",    64'(bus_a.we),            64'(m_wr));
    chk("we_b",    64'(bus_b.we),            64'(m_wr));
    chk("ready_a", 64'(bus_a.din_ready),     64'(m_active && !m_wr));
    chk("ready_b", 64'(bus_b.din_ready),     64'(m_active && !m_wr));
    chk("busy_a",  64'(busy_a),              64'(m_active));
    chk("busy_b",  64'(busy_b),              64'(m_active));
    chk("done_a",  64'(done_a),              64'(m_done));
    chk("done_b",  64'(done_b),              64'(m_done));
    chk("addr_a",  64'(bus_a.im_write_addr), 64'(m_waddr));
    chk("addr_b",  64'(bus_b.im_write_addr), 64'(m_waddr));
    chk("din_a",   bus_a.im_din,             m_wdata);
    chk("din_b",   64'(bus_b.im_din),        64'(m_wdata[39:0]));
`ifdef IM_LOADER_CHECKSUM_EN
    if (m_done) begin
      chk("cs_a", 64'(cs_a), 64'(m_cs));
      chk("cs_b", 64'(cs_b), 64'(m_cs));
    end
`endif
  endtask

  task automatic tick(input bit r, input bit s, input bit v, input logic [31:0] d);
    drv_rst = r; drv_start = s; drv_valid = v; drv_din = d;
    @(posedge clk);
    model_step(r, s, v, d);
    @(negedge clk);
    check_model();
    if (bus_a.we === 1'b1) wr_q.push_back(bus_a.im_write_addr);
  endtask

  // Feed n beats (values 1..n); optional valid-low stall before beat
  // index stall_at and a start pulse while beat index pulse_at is offered.
  task automatic send_beats(input int n, input int stall_at, input int stall_len,
                            input int pulse_at);
    int k = 0;
    int stalled = 0;
    bit pulsed = 0;
    int budget = 200;
    while (k < n && budget > 0) begin
      budget--;
      if (k == stall_at && stalled < stall_len) begin
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        stalled++;
      end else begin
        bit acc;
        bit ps;
        acc = m_active && !m_wr;
        ps  = (k == pulse_at) && !pulsed;
        if (ps) pulsed = 1;
        tick(1'b0, ps, 1'b1, 32'(k + 1));
        if (acc) k++;
      end
    end
    if (k < n) begin
      total++; bad++;
      $display("FAIL send_beats budget actual=%0d required=%0d beats", k, n);
    end
  endtask

  task automatic check_writes(input string nm);
    chk({nm, ".count"}, 64'(wr_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk({nm, ".addr"}, (i < wr_q.size()) ? 64'(wr_q[i]) : 64'hFFFF, 64'(i));
  endtask

  typedef struct {
    bit          r, s, v;
    logic [31:0] d;
    bit          we;
    logic [9:0]  addr;
    logic [63:0] da;
    logic [39:0] db;
    bit          rdy, done;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Directed table: first word, 40-bit truncation, third word, DONE.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 10'd0, 64'h0, 40'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 10'd0, 64'h0, 40'h0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 10'd0, 64'h0, 40'h0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 10'd0,
                 64'h2222222211111111, 40'h2211111111, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'd0,
                 64'h2222222211111111, 40'h2211111111, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0, 10'd0,
                 64'h2222222211111111, 40'h2211111111, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFBB, 1'b1, 10'd1,
                 64'hFFFFFFBBAAAAAAAA, 40'hBBAAAAAAAA, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'd1,
                 64'hFFFFFFBBAAAAAAAA, 40'hBBAAAAAAAA, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 10'd1,
                 64'hFFFFFFBBAAAAAAAA, 40'hBBAAAAAAAA, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h2,        1'b1, 10'd2,
                 64'h0000000200000001, 40'h0200000001, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'd2,
                 64'h0000000200000001, 40'h0200000001, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h5,        1'b0, 10'd2,
                 64'h0000000200000001, 40'h0200000001, 1'b0, 1'b1};

    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d.we", i),    64'(bus_a.we),            64'(vecs[i].we));
      chk($sformatf("vec%0d.addr", i),  64'(bus_a.im_write_addr), 64'(vecs[i].addr));
      chk($sformatf("vec%0d.din_a", i), bus_a.im_din,             vecs[i].da);
      chk($sformatf("vec%0d.din_b", i), 64'(bus_b.im_din),        64'(vecs[i].db));
      chk($sformatf("vec%0d.ready", i), 64'(bus_a.din_ready),     64'(vecs[i].rdy));
      chk($sformatf("vec%0d.done", i),  64'(done_a),              64'(vecs[i].done));
    end

    // start in DONE reloads; start pulsed mid-load is ignored
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("reload.done_drop", 64'(done_a), 64'd0);
    chk("reload.ready",     64'(bus_a.din_ready), 64'd1);
    wr_q.delete();
    send_beats(6, -1, 0, 2);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check_writes("start_in_load");
    chk("start_in_load.done", 64'(done_a), 64'd1);

    // 6 beats with a 5-cycle valid gap between beats 3 and 4
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    wr_q.delete();
    send_beats(6, 3, 5, -1);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check_writes("stall");
    chk("stall.done",  64'(done_a), 64'd1);
    chk("stall.ready", 64'(bus_a.din_ready), 64'd0);
`ifdef IM_LOADER_CHECKSUM_EN
    chk("checksum_1to6", 64'(cs_a), 64'h7);
`endif
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall.ready_after", 64'(bus_a.din_ready), 64'd0);

    // rst after beat 3 abandons the partial word
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    send_beats(3, -1, 0, -1);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst.we",    64'(bus_a.we), 64'd0);
    chk("rst.ready", 64'(bus_a.din_ready), 64'd0);
    chk("rst.busy",  64'(busy_a), 64'd0);
    chk("rst.done",  64'(done_a), 64'd0);
    chk("rst.addr",  64'(bus_a.im_write_addr), 64'd0);
    chk("rst.din",   bus_a.im_din, 64'd0);
    wr_q.delete();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 32'hDEAD0000);
    chk("rst.no_writes", 64'(wr_q.size()), 64'd0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    wr_q.delete();
    send_beats(6, -1, 0, -1);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    check_writes("after_rst");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit r, s, v;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 14) == 0);
      v = ($urandom_range(0, 3) != 0);
      tick(r, s, v, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
